vx_gpu_req_arb: RTL and testbench

//  Shares the single GPU unit (warp control: tmc/wspawn/split/join/bar/pred) between NUM_REQS

---
 rtl/vx_gpu_req_arb_pkg.sv | 31 +++
 rtl/vx_gpu_req_arb_rr.sv | 40 ++++
 rtl/vx_gpu_req_arb.sv | 136 +++++++++++++
 tb/tb_vx_gpu_req_arb.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/vx_gpu_req_arb_pkg.sv
// Shared types and helpers for the GPU-unit request arbiter.
// Combinational only: types, field widths and a select-width helper.
// No flow control here; consumers of gpu_req_t carry their own valid/ready.
package vx_gpu_req_arb_pkg;

  // Packed warp-control request as issued by one dispatch slot.
  typedef struct packed {
    logic [43:0] uuid;
    logic [3:0]  wid;
    logic [15:0] tmask;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic [3:0]  op_type;
    logic [3:0]  op_mod;
    logic [3:0]  tid;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] rs3_data;
    logic [4:0]  rd;
    logic        wb;
    logic [13:0] rsvd;      // keeps the request a round 256 bits
  } gpu_req_t;

  localparam int GPU_REQ_DATAW = $bits(gpu_req_t);

  // Index width for n items, never narrower than one bit.
  function automatic int up_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_gpu_req_arb_rr.sv
// Round-robin grant: req_i, ptr_i -> one-hot grant_o, index idx_o, any-grant valid_o.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller masks the grant when it cannot accept.
// Ports: req_i request vector, ptr_i last granted slot (search starts one above it).
module vx_gpu_req_arb_rr
  import vx_gpu_req_arb_pkg::*;
#(
  parameter int NUM_REQS = 4,
  parameter int SEL_W    = up_clog2(NUM_REQS)
) (
  input  logic [NUM_REQS-1:0] req_i,
  input  logic [SEL_W-1:0]    ptr_i,
  output logic [NUM_REQS-1:0] grant_o,
  output logic [SEL_W-1:0]    idx_o,
  output logic                valid_o
);

  always_comb begin
    int  cand;
    logic found;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = 0;
    // Visit slots ptr+1, ptr+2, ... wrapping; the first requester wins.
    // The inner loop keeps every bit select constant.
    for (int k = 1; k <= NUM_REQS; k++) begin
      cand = (int'(ptr_i) + k) % NUM_REQS;
      for (int j = 0; j < NUM_REQS; j++) begin
        if (!found && (j == cand) && req_i[j]) begin
          found      = 1'b1;
          grant_o[j] = 1'b1;
          idx_o      = SEL_W'(j);
        end
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/vx_gpu_req_arb.sv
// Shares the GPU unit between NUM_REQS issue slots: round-robin grant into a 2-entry skid buffer.
// Latency: 1 cycle from input handshake to out_valid_o; 1 request/cycle sustained.
// Backpressure: req_ready_o drops only when the buffer is full; no combinational out_ready_i->req_ready_o path.
// Ports: clk_i/reset_i (async, active-high); req_valid_i/req_data_i/req_ready_o per slot;
//        out_valid_o/out_data_o/out_sel_o/out_ready_i to the GPU unit; perf_stalls_o saturating stall count.
module vx_gpu_req_arb
  import vx_gpu_req_arb_pkg::*;
#(
  parameter int NUM_REQS = 4,
  parameter int DATAW    = GPU_REQ_DATAW,
  parameter int PERF_W   = 44,
  localparam int SEL_W   = up_clog2(NUM_REQS)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [NUM_REQS-1:0]       req_valid_i,
  input  logic [NUM_REQS*DATAW-1:0] req_data_i,
  output logic [NUM_REQS-1:0]       req_ready_o,
  output logic                      out_valid_o,
  output logic [DATAW-1:0]          out_data_o,
  output logic [SEL_W-1:0]          out_sel_o,
  input  logic                      out_ready_i,
  output logic [PERF_W-1:0]         perf_stalls_o
);

  logic [SEL_W-1:0]    ptr_q, ptr_d;
  logic [1:0]          count_q, count_d;
  logic [DATAW-1:0]    head_dat_q, head_dat_d;
  logic [SEL_W-1:0]    head_sel_q, head_sel_d;
  logic [DATAW-1:0]    skid_dat_q, skid_dat_d;
  logic [SEL_W-1:0]    skid_sel_q, skid_sel_d;
  logic [PERF_W-1:0]   perf_q, perf_d;

  logic [NUM_REQS-1:0] grant;
  logic [SEL_W-1:0]    grant_idx;
  logic                grant_vld;
  logic                full;
  logic                push;
  logic                pop;
  logic [DATAW-1:0]    new_dat;

  vx_gpu_req_arb_rr #(
    .NUM_REQS (NUM_REQS),
    .SEL_W    (SEL_W)
  ) u_rr (
    .req_i   (req_valid_i),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (grant_idx),
    .valid_o (grant_vld)
  );

  assign full        = (count_q == 2'd2);
  assign req_ready_o = (reset_i || full) ? '0 : grant;
  assign push        = grant_vld && !full;
  assign out_valid_o = (count_q != 2'd0);
  assign pop         = out_valid_o && out_ready_i;
  assign out_data_o  = head_dat_q;
  assign out_sel_o   = head_sel_q;
  assign perf_stalls_o = perf_q;

  // Payload of the granted slot; constant slices only.
  always_comb begin
    new_dat = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (grant[i]) new_dat = req_data_i[i*DATAW +: DATAW];
    end
  end

  always_comb begin
    count_d    = count_q;
    head_dat_d = head_dat_q;
    head_sel_d = head_sel_q;
    skid_dat_d = skid_dat_q;
    skid_sel_d = skid_sel_q;
    ptr_d      = push ? grant_idx : ptr_q;
    perf_d     = perf_q;

    case (count_q)
      2'd0: begin
        if (push) begin
          head_dat_d = new_dat;
          head_sel_d = grant_idx;
          count_d    = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          // Head leaves this cycle, so the newcomer goes straight to head.
          head_dat_d = new_dat;
          head_sel_d = grant_idx;
        end else if (push) begin
          skid_dat_d = new_dat;
          skid_sel_d = grant_idx;
          count_d    = 2'd2;
        end else if (pop) begin
          count_d    = 2'd0;
        end
      end
      default: begin
        // Full: no push is possible, a pop promotes the skid entry.
        if (pop) begin
          head_dat_d = skid_dat_q;
          head_sel_d = skid_sel_q;
          count_d    = 2'd1;
        end
      end
    endcase

    if ((|req_valid_i) && full && (perf_q != '1)) begin
      perf_d = perf_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      // Slot 0 gets first priority after reset.
      ptr_q      <= SEL_W'(NUM_REQS - 1);
      count_q    <= 2'd0;
      head_dat_q <= '0;
      head_sel_q <= '0;
      skid_dat_q <= '0;
      skid_sel_q <= '0;
      perf_q     <= '0;
    end else begin
      ptr_q      <= ptr_d;
      count_q    <= count_d;
      head_dat_q <= head_dat_d;
      head_sel_q <= head_sel_d;
      skid_dat_q <= skid_dat_d;
      skid_sel_q <= skid_sel_d;
      perf_q     <= perf_d;
    end
  end

endmodule

// File: tb/tb_vx_gpu_req_arb.sv
module tb_vx_gpu_req_arb;

  localparam int N  = 4;
  localparam int DW = 256;
  localparam int PW = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_sel;
  logic            out_ready;
  logic [PW-1:0]   perf_stalls;

  always #5 clk = ~clk;

  vx_gpu_req_arb #(
    .NUM_REQS (N),
    .DATAW    (DW),
    .PERF_W   (PW)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .req_valid_i   (req_valid),
    .req_data_i    (req_data),
    .req_ready_o   (req_ready),
    .out_valid_o   (out_valid),
    .out_data_o    (out_data),
    .out_sel_o     (out_sel),
    .out_ready_i   (out_ready),
    .perf_stalls_o (perf_stalls)
  );

  // Reference model: FIFO of accepted requests, last-granted slot, stall count.
  typedef struct {
    logic [DW-1:0] d;
    int            s;
  } ent_t;

  ent_t q[$];
  int   m_ptr;
  int   m_perf;
  int   vecs;
  int   miscmp;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miscmp++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd256();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic rnd_data();
    for (int s = 0; s < N; s++) req_data[s*DW +: DW] = rnd256();
  endtask

  // Called at posedge+1 with inputs applied; checks, advances model, returns at next posedge+1.
  task automatic cycle();
    int           g;
    logic [N-1:0] exp_rdy;
    #3;
    g       = -1;
    exp_rdy = '0;
    if (q.size() < 2) begin
      for (int k = 1; k <= N; k++) begin
        if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", DW'(req_ready), DW'(exp_rdy));
    chk("out_valid", DW'(out_valid), DW'(q.size() != 0));
    if (q.size() != 0) begin
      chk("out_data", out_data, q[0].d);
      chk("out_sel", DW'(out_sel), DW'(q[0].s));
    end
    chk("perf_stalls", DW'(perf_stalls), DW'(m_perf));
    if ((|req_valid) && q.size() == 2 && m_perf < (1 << PW) - 1) m_perf++;
    if (q.size() != 0 && out_ready) q.delete(0);
    if (g >= 0) begin
      q.push_back('{d: req_data[g*DW +: DW], s: g});
      m_ptr = g;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #3;
    chk("rst_req_ready", DW'(req_ready), '0);
    chk("rst_out_valid", DW'(out_valid), '0);
    chk("rst_perf", DW'(perf_stalls), '0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_sel", DW'(out_sel), '0);
    q.delete();
    m_ptr  = N - 1;
    m_perf = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  logic [DW-1:0] da, db;

  initial begin
    vecs      = 0;
    miscmp    = 0;
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b0;
    #1;
    req_valid = 4'b1111;
    do_reset();

    // Rotation with all slots requesting and the sink always ready.
    req_valid = 4'b1111;
    out_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      rnd_data();
      cycle();
      chk("rotation_sel", DW'(out_sel), DW'(k % N));
      chk("rotation_vld", DW'(out_valid), DW'(1'b1));
    end

    // Wrap and skip: park the pointer at slot 2, then only slots 0 and 1 request.
    req_valid = 4'b0000;
    cycle();
    cycle();
    req_valid = 4'b0100;
    cycle();
    req_valid = 4'b0011;
    #3 chk("wrap_g0", DW'(req_ready), DW'(4'b0001));
    cycle();
    #3 chk("wrap_g1", DW'(req_ready), DW'(4'b0010));
    cycle();
    #3 chk("wrap_g2", DW'(req_ready), DW'(4'b0001));
    cycle();

    // Back-pressure: sink stalled, slot 0 requests for five cycles.
    do_reset();
    out_ready = 1'b0;
    req_valid = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      rnd_data();
      if (k == 0) da = req_data[0 +: DW];
      if (k == 1) db = req_data[0 +: DW];
      cycle();
    end
    #3;
    chk("bp_ready", DW'(req_ready), '0);
    chk("bp_perf", DW'(perf_stalls), DW'(3));
    req_valid = 4'b0000;
    out_ready = 1'b1;
    chk("bp_first", out_data, da);
    cycle();
    chk("bp_second", out_data, db);
    cycle();
    chk("bp_empty", DW'(out_valid), '0);

    // Push and pop together at count 1: no bubble between A and B.
    req_valid = 4'b0001;
    rnd_data();
    da = req_data[0 +: DW];
    cycle();
    chk("pp_a", out_data, da);
    req_valid = 4'b0010;
    rnd_data();
    db = req_data[DW +: DW];
    cycle();
    chk("pp_b", out_data, db);
    chk("pp_b_vld", DW'(out_valid), DW'(1'b1));
    req_valid = 4'b0000;
    cycle();

    // Saturation of the 4-bit stall counter.
    out_ready = 1'b0;
    req_valid = 4'b0001;
    for (int k = 0; k < 22; k++) cycle();
    chk("sat_perf", DW'(perf_stalls), DW'(4'hF));
    for (int k = 0; k < 3; k++) cycle();
    chk("sat_hold", DW'(perf_stalls), DW'(4'hF));

    // Reset while full: buffer and counter clear.
    req_valid = 4'b1111;
    do_reset();
    chk("post_rst_vld", DW'(out_valid), '0);

    // Randomised traffic against the model.
    for (int k = 0; k < 600; k++) begin
      req_valid = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      rnd_data();
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end

endmodule
